// File: rtl/rv32i_dmi_pkg.sv
// Shared DMI definitions: default widths, op/resp codes and the arbiter FSM states.
package rv32i_dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;
    localparam int DMI_OP_W   = 2;
    localparam int TX_W       = DMI_ADDR_W + DMI_DATA_W + DMI_OP_W;
    localparam int RX_W       = DMI_DATA_W + DMI_OP_W;

    // Channel index width; enough for up to 8 requesters.
    localparam int CH_IDX_W   = 3;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;

    localparam logic [1:0] RESP_OK    = 2'd0;
    localparam logic [1:0] RESP_FAIL  = 2'd2;
    localparam logic [1:0] RESP_BUSY  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } dmi_state_e;

endpackage

// File: rtl/rv32i_dmi_arb_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping at NUM_CH.
module rr_arb
    import rv32i_dmi_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_IDX_W-1:0] ptr,
    input  logic                en,
    output logic [NUM_CH-1:0]   gnt,
    output logic [CH_IDX_W-1:0] idx
);

    // Zero-extended so the scan can index with a full 3-bit candidate.
    logic [7:0] req_ext;
    logic       found;
    logic [3:0] cand;

    assign req_ext = 8'(req);

    // Scan candidates ptr, ptr+1, ... modulo NUM_CH; first active request wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(NUM_CH)) begin
                cand = cand - 4'(NUM_CH);
            end
            if (en && !found && req_ext[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand[2:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_gnt
            assign gnt[gi] = found && (idx == CH_IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rv32i_dmi_arb.sv
// Multi-channel DMI arbiter in front of the core DMI port, with response routing,
// memory-ready gating and a response timeout that returns FAIL to the requester.
module rv32i_dmi_arb
    import rv32i_dmi_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = DMI_ADDR_W,
    parameter int DATA_W  = DMI_DATA_W,
    parameter int OP_W    = DMI_OP_W,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_CH-1:0]                      ch_req_vld,
    input  logic [NUM_CH*(ADDR_W+DATA_W+OP_W)-1:0] ch_req_data,
    output logic [NUM_CH-1:0]                      ch_req_rdy,
    output logic [NUM_CH-1:0]                      ch_resp_vld,
    output logic [DATA_W+OP_W-1:0]                 ch_resp_data,
    input  logic [NUM_CH-1:0]                      ch_resp_rdy,
    input  logic                                   mem_ready,
    output logic                                   io_dmi_req_valid,
    output logic [ADDR_W-1:0]                      io_dmi_req_bits_addr,
    output logic [DATA_W-1:0]                      io_dmi_req_bits_data,
    output logic [OP_W-1:0]                        io_dmi_req_bits_op,
    input  logic                                   io_dmi_req_ready,
    input  logic                                   io_dmi_resp_valid,
    input  logic [DATA_W-1:0]                      io_dmi_resp_bits_data,
    input  logic [OP_W-1:0]                        io_dmi_resp_bits_resp,
    output logic                                   io_dmi_resp_ready,
    output logic                                   busy,
    output logic [2:0]                             grant_ch,
    output logic [CNT_W-1:0]                       timeout_cnt,
    output logic [CNT_W-1:0]                       stale_cnt
);

    localparam int REQ_W = ADDR_W + DATA_W + OP_W;
    localparam int RSP_W = DATA_W + OP_W;
    // One spare bit so a late request handshake in the expiry cycle cannot wrap the timer.
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    dmi_state_e          state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          grant_q, grant_d;
    logic [REQ_W-1:0]    tx_q, tx_d;
    logic [RSP_W-1:0]    rx_q, rx_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0]    stale_cnt_q, stale_cnt_d;

    logic [REQ_W-1:0]    req_word [NUM_CH];
    logic [REQ_W-1:0]    req_sel;
    logic [NUM_CH-1:0]   arb_gnt;
    logic [2:0]          arb_idx;
    logic                arb_en;
    logic                arb_found;
    logic [2:0]          ptr_next;
    logic                expired;
    logic                resp_take;
    logic [RSP_W-1:0]    rsp_fail;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign req_word[gi]    = ch_req_data[gi*REQ_W +: REQ_W];
            assign ch_resp_vld[gi] = (state_q == ST_RETURN) && (grant_q == 3'(gi));
        end
    endgenerate

    // Grants only from IDLE with memory ready; nothing is offered while reset is held.
    assign arb_en = (state_q == ST_IDLE) && mem_ready && !reset;

    rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_rr_arb (
        .req (ch_req_vld),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_found  = |arb_gnt;
    assign ptr_next   = (arb_idx == 3'(NUM_CH - 1)) ? 3'd0 : arb_idx + 3'd1;
    assign expired    = (timer_q >= TMR_W'(TIMEOUT - 1));
    assign resp_take  = |(ch_resp_vld & ch_resp_rdy);
    assign rsp_fail   = {{DATA_W{1'b0}}, OP_W'(RESP_FAIL)};

    // One-hot mux of the winning channel's {addr,data,op}.
    always_comb begin
        req_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (arb_gnt[k]) begin
                req_sel = req_word[k];
            end
        end
    end

    // Next-state logic: arbitration, core handshakes, timeout and counter updates.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        timer_d       = timer_q;
        timeout_cnt_d = timeout_cnt_q;
        stale_cnt_d   = stale_cnt_q;

        // Core responses are always accepted; outside WAIT they belong to nobody.
        if (io_dmi_resp_valid && (state_q != ST_WAIT)) begin
            if (stale_cnt_q != {CNT_W{1'b1}}) begin
                stale_cnt_d = stale_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    tx_d    = req_sel;
                    grant_d = arb_idx;
                    ptr_d   = ptr_next;
                    timer_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = timer_q + TMR_W'(1);
                if (io_dmi_req_ready) begin
                    state_d = ST_WAIT;
                end else if (expired) begin
                    rx_d    = rsp_fail;
                    state_d = ST_RETURN;
                    if (timeout_cnt_q != {CNT_W{1'b1}}) begin
                        timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (io_dmi_resp_valid) begin
                    rx_d    = {io_dmi_resp_bits_data, io_dmi_resp_bits_resp};
                    state_d = ST_RETURN;
                end else if (expired) begin
                    rx_d    = rsp_fail;
                    state_d = ST_RETURN;
                    if (timeout_cnt_q != {CNT_W{1'b1}}) begin
                        timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RETURN: begin
                if (resp_take) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            timer_q       <= '0;
            timeout_cnt_q <= '0;
            stale_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            timer_q       <= timer_d;
            timeout_cnt_q <= timeout_cnt_d;
            stale_cnt_q   <= stale_cnt_d;
        end
    end

    assign ch_req_rdy        = arb_gnt;
    assign io_dmi_req_valid  = (state_q == ST_ISSUE);
    assign {io_dmi_req_bits_addr, io_dmi_req_bits_data, io_dmi_req_bits_op} = tx_q;
    assign io_dmi_resp_ready = 1'b1;
    assign ch_resp_data      = rx_q;
    assign busy              = (state_q != ST_IDLE);
    assign grant_ch          = grant_q;
    assign timeout_cnt       = timeout_cnt_q;
    assign stale_cnt         = stale_cnt_q;

endmodule

// File: tb/tb_rv32i_dmi_arb.sv
// Bench for rv32i_dmi_arb: directed vector table, hand sequences and random traffic.
module tb_rv32i_dmi_arb;
    import rv32i_dmi_pkg::*;

    localparam int NCH = 3;
    localparam int TO  = 16;
    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int OW  = 2;
    localparam int RW  = AW + DW + OW;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req_vld;
    logic [NCH*RW-1:0] ch_req_data;
    logic [NCH-1:0]    ch_req_rdy;
    logic [NCH-1:0]    ch_resp_vld;
    logic [DW+OW-1:0]  ch_resp_data;
    logic [NCH-1:0]    ch_resp_rdy;
    logic              mem_ready;
    logic              io_dmi_req_valid;
    logic [AW-1:0]     io_dmi_req_bits_addr;
    logic [DW-1:0]     io_dmi_req_bits_data;
    logic [OW-1:0]     io_dmi_req_bits_op;
    logic              io_dmi_req_ready;
    logic              io_dmi_resp_valid;
    logic [DW-1:0]     io_dmi_resp_bits_data;
    logic [OW-1:0]     io_dmi_resp_bits_resp;
    logic              io_dmi_resp_ready;
    logic              busy;
    logic [2:0]        grant_ch;
    logic [CW-1:0]     timeout_cnt;
    logic [CW-1:0]     stale_cnt;

    always #5 clk = ~clk;

    rv32i_dmi_arb #(
        .NUM_CH (NCH), .ADDR_W (AW), .DATA_W (DW), .OP_W (OW), .TIMEOUT (TO), .CNT_W (CW)
    ) dut (
        .clock                 (clk),
        .reset                 (reset),
        .ch_req_vld            (ch_req_vld),
        .ch_req_data           (ch_req_data),
        .ch_req_rdy            (ch_req_rdy),
        .ch_resp_vld           (ch_resp_vld),
        .ch_resp_data          (ch_resp_data),
        .ch_resp_rdy           (ch_resp_rdy),
        .mem_ready             (mem_ready),
        .io_dmi_req_valid      (io_dmi_req_valid),
        .io_dmi_req_bits_addr  (io_dmi_req_bits_addr),
        .io_dmi_req_bits_data  (io_dmi_req_bits_data),
        .io_dmi_req_bits_op    (io_dmi_req_bits_op),
        .io_dmi_req_ready      (io_dmi_req_ready),
        .io_dmi_resp_valid     (io_dmi_resp_valid),
        .io_dmi_resp_bits_data (io_dmi_resp_bits_data),
        .io_dmi_resp_bits_resp (io_dmi_resp_bits_resp),
        .io_dmi_resp_ready     (io_dmi_resp_ready),
        .busy                  (busy),
        .grant_ch              (grant_ch),
        .timeout_cnt           (timeout_cnt),
        .stale_cnt             (stale_cnt)
    );

    // Reference model state.
    int ptr_m;
    int to_m;
    int st_m;
    int txn_no;

    int total;
    int bad;

    typedef struct {
        logic [2:0]  mask;
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        int          req_lat;
        int          resp_lat;
        logic [31:0] rdata;
        logic [1:0]  rcode;
        int          hold;
        int          exp_ch;
        logic [33:0] exp_rx;
    } vec_t;

    vec_t tab [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [2:0] mask, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (mask[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    // Cycle 0 is the first ISSUE cycle; the core accepts in cycle req_lat and answers
    // resp_lat cycles after that. Completion in cycle TO-1 still beats the timeout.
    function automatic bit times_out(input int req_lat, input int resp_lat);
        return (req_lat >= TO - 1) || (req_lat + 1 + resp_lat > TO - 1);
    endfunction

    // Plays one requester-and-core round trip starting and ending at a falling edge in IDLE.
    task automatic run_txn(input logic [2:0] mask, input logic [1:0] op, input logic [6:0] addr,
                           input logic [31:0] wdata, input int req_lat, input int resp_lat,
                           input logic [31:0] rdata, input logic [1:0] rcode, input int hold,
                           output int act_ch, output logic [33:0] act_rx);
        int          w;
        int          r;
        int          end_c;
        bit          tmo;
        logic [RW-1:0] word;
        logic [2:0]  wbit;
        w     = pick(mask, ptr_m);
        wbit  = 3'b001 << w;
        r     = req_lat + 1 + resp_lat;
        tmo   = times_out(req_lat, resp_lat);
        end_c = tmo ? TO : r + 1;
        word  = {addr, wdata, op};
        for (int k = 0; k < NCH; k++) begin
            ch_req_data[k*RW +: RW] = (k == w) ? word : RW'({$urandom, $urandom});
        end
        ch_req_vld = mask;
        #1;
        chk("req_rdy", ch_req_rdy, wbit);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        ch_req_vld = mask & ~wbit;
        ptr_m = (w + 1) % NCH;
        chk("req_fields", {io_dmi_req_bits_addr, io_dmi_req_bits_data, io_dmi_req_bits_op}, word);
        for (int c = 0; c < end_c; c++) begin
            chk("req_valid", io_dmi_req_valid, (c <= req_lat));
            chk("early_resp_vld", ch_resp_vld, 0);
            chk("busy_rdy", {busy, ch_req_rdy}, {1'b1, 3'b000});
            chk("resp_ready", io_dmi_resp_ready, 1);
            mem_ready             = 1'($urandom_range(0, 1));
            io_dmi_req_ready      = (c == req_lat);
            io_dmi_resp_valid     = !tmo && (c == r);
            io_dmi_resp_bits_data = (!tmo && c == r) ? rdata : $urandom;
            io_dmi_resp_bits_resp = (!tmo && c == r) ? rcode : 2'($urandom);
            @(negedge clk);
        end
        io_dmi_req_ready  = 1'b0;
        io_dmi_resp_valid = 1'b0;
        mem_ready         = 1'b1;
        chk("ret_vld", ch_resp_vld, wbit);
        chk("ret_req_valid", io_dmi_req_valid, 0);
        act_ch = int'(grant_ch);
        act_rx = ch_resp_data;
        for (int h = 0; h < hold; h++) begin
            ch_resp_rdy = ~wbit;
            @(negedge clk);
            chk("hold_vld", ch_resp_vld, wbit);
            chk("hold_data", ch_resp_data, act_rx);
        end
        ch_resp_rdy = wbit;
        @(negedge clk);
        ch_resp_rdy = '0;
        ch_req_vld  = '0;
        chk("done_idle", {busy, ch_resp_vld}, 0);
        if (tmo) to_m++;
        chk("timeout_cnt", timeout_cnt, to_m);
        chk("stale_cnt", stale_cnt, st_m);
        $display("txn %0d: mask=%b ch=%0d resp=%h timeout=%0d", txn_no, mask, act_ch, act_rx, tmo);
        txn_no++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          act_ch;
        logic [33:0] act_rx;
        logic [33:0] exp_rx;
        logic [2:0]  mask;
        int          exp_ch;
        int          rl;
        int          sl;
        logic [31:0] rdata;
        logic [1:0]  rcode;
        logic [1:0]  codes [3];

        total = 0; bad = 0; txn_no = 0;
        ptr_m = 0; to_m = 0; st_m = 0;
        codes[0] = RESP_OK; codes[1] = RESP_FAIL; codes[2] = RESP_BUSY;

        // mask, op, addr, wdata, req_lat, resp_lat, rdata, rcode, hold, exp_ch, exp_rx
        tab[0] = '{3'b001, OP_READ,  7'h10, 32'h0,        0,  2, 32'hDEADBEEF, RESP_OK,   0, 0, {32'hDEADBEEF, 2'd0}};
        tab[1] = '{3'b111, OP_WRITE, 7'h04, 32'h12345678, 1,  0, 32'h0,        RESP_OK,   2, 1, {32'h0, 2'd0}};
        tab[2] = '{3'b101, OP_READ,  7'h11, 32'h0,        3,  4, 32'hCAFEF00D, RESP_BUSY, 1, 2, {32'hCAFEF00D, 2'd3}};
        tab[3] = '{3'b110, OP_READ,  7'h20, 32'h0,        0,  0, 32'h00000001, RESP_FAIL, 0, 1, {32'h00000001, 2'd2}};
        tab[4] = '{3'b011, OP_READ,  7'h30, 32'h0,        2, 20, 32'h55,       RESP_OK,   0, 0, {32'h0, 2'd2}};
        tab[5] = '{3'b100, OP_NOP,   7'h00, 32'h0,       14,  0, 32'hA5A5A5A5, RESP_OK,   1, 2, {32'hA5A5A5A5, 2'd0}};
        tab[6] = '{3'b001, OP_WRITE, 7'h7F, 32'hFFFFFFFF, 0, 15, 32'h9,        RESP_OK,   0, 0, {32'h0, 2'd2}};
        tab[7] = '{3'b010, OP_READ,  7'h01, 32'h0,       20,  0, 32'h7,        RESP_OK,   0, 1, {32'h0, 2'd2}};

        reset = 1'b1;
        ch_req_vld = 3'b111; ch_req_data = '0; ch_resp_rdy = '0; mem_ready = 1'b1;
        io_dmi_req_ready = 1'b0; io_dmi_resp_valid = 1'b0;
        io_dmi_resp_bits_data = '0; io_dmi_resp_bits_resp = '0;

        @(negedge clk);
        chk("reset_outs", {busy, io_dmi_req_valid, ch_req_rdy, ch_resp_vld, grant_ch}, 0);
        chk("reset_resp_ready", io_dmi_resp_ready, 1);
        chk("reset_cnts", {timeout_cnt, stale_cnt, ch_resp_data}, 0);
        reset = 1'b0;
        ch_req_vld = '0;

        for (int i = 0; i < 8; i++) begin
            run_txn(tab[i].mask, tab[i].op, tab[i].addr, tab[i].wdata, tab[i].req_lat,
                    tab[i].resp_lat, tab[i].rdata, tab[i].rcode, tab[i].hold, act_ch, act_rx);
            chk("tab_ch", act_ch, tab[i].exp_ch);
            chk("tab_rx", act_rx, tab[i].exp_rx);
        end

        // A late core response after the timeouts must be dropped and counted.
        repeat (5) @(negedge clk);
        io_dmi_resp_valid = 1'b1;
        io_dmi_resp_bits_data = 32'hBAADF00D;
        @(negedge clk);
        io_dmi_resp_valid = 1'b0;
        st_m++;
        chk("stale_late", stale_cnt, st_m);
        chk("stale_no_ret", {busy, ch_resp_vld}, 0);

        // Memory not ready: requests must wait without any handshake.
        mem_ready  = 1'b0;
        ch_req_vld = 3'b010;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("memwait_rdy", ch_req_rdy, 0);
            chk("memwait_valid", io_dmi_req_valid, 0);
        end
        mem_ready = 1'b1;
        run_txn(3'b010, OP_READ, 7'h22, 32'h0, 0, 1, 32'h13579BDF, RESP_OK, 0, act_ch, act_rx);
        chk("memwait_ch", act_ch, 1);
        chk("memwait_rx", act_rx, {32'h13579BDF, 2'd0});

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            mask   = 3'($urandom_range(1, 7));
            exp_ch = pick(mask, ptr_m);
            rl     = $urandom_range(0, 12);
            sl     = $urandom_range(0, 8);
            rdata  = $urandom;
            rcode  = codes[$urandom_range(0, 2)];
            exp_rx = times_out(rl, sl) ? {32'h0, RESP_FAIL} : {rdata, rcode};
            run_txn(mask, 2'($urandom_range(0, 2)), 7'($urandom), $urandom, rl, sl, rdata, rcode,
                    $urandom_range(0, 2), act_ch, act_rx);
            chk("rand_ch", act_ch, exp_ch);
            chk("rand_rx", act_rx, exp_rx);
        end

        // Asynchronous reset in the middle of WAIT.
        ch_req_data[1*RW +: RW] = {7'h05, 32'h0, OP_READ};
        ch_req_vld = 3'b010;
        ptr_m = pick(3'b010, ptr_m) + 1;
        @(negedge clk);
        ch_req_vld = '0;
        io_dmi_req_ready = 1'b1;
        @(negedge clk);
        io_dmi_req_ready = 1'b0;
        ch_req_vld = 3'b111;
        chk("pre_rst_busy", {busy, grant_ch}, {1'b1, 3'd1});
        #2;
        reset = 1'b1;
        #1;
        chk("arst_outs", {busy, io_dmi_req_valid, ch_req_rdy, ch_resp_vld, grant_ch}, 0);
        chk("arst_resp_ready", io_dmi_resp_ready, 1);
        chk("arst_cnts", {timeout_cnt, stale_cnt, ch_resp_data}, 0);
        ch_req_vld = '0;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0; to_m = 0; st_m = 0;
        run_txn(3'b111, OP_READ, 7'h3C, 32'h0, 0, 0, 32'h0BADCAFE, RESP_OK, 0, act_ch, act_rx);
        chk("post_rst_ch", act_ch, 0);
        chk("post_rst_rx", act_rx, {32'h0BADCAFE, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
